magma_xbar: RTL and testbench
=============================

// Module: magma_xbar
// PURPOSE
//  Parametrised M_NUM x S_NUM interconnect for the magma req/ack/resp bus; successor of the fixed 5x5 crossbar.
//  Sits between tile xbus/udm masters and tile hpi/gpio slaves.
//  Adds per-slave round-robin arbitration with grant lock, per-slave read-ID FIFOs and per-master outstanding-read limits.
//  Adds an internal error slave for unmapped addresses.
// PARAMETERS
//  M_NUM       5   number of masters (1..16)
//  S_NUM       5   number of slaves (1..15); slave index = addr[31:28]
//  RD_DEPTH    4   per-slave outstanding-read ID FIFO depth (power of 2, >=2)
//  MAX_OUTST   4   max outstanding reads per master (>=1)
//  ERR_RDATA   32'hDEADBEEF  read data returned for unmapped addresses
// PORTS
//  clk_i        in   1          clock
//  rst_i        in   1          synchronous reset, active-high
//  m_req_i      in   M_NUM      master request
//  m_we_i       in   M_NUM      1=write, 0=read
//  m_addr_bi    in   M_NUM*32   address, master k at [32k+:32]
//  m_be_i       in   M_NUM*4    byte enables
//  m_wdata_bi   in   M_NUM*32   write data
//  m_ack_o      out  M_NUM      request accepted
//  m_resp_o     out  M_NUM      read data valid (1-cycle pulse)
//  m_rdata_bo   out  M_NUM*32   read data
//  s_req_o      out  S_NUM      slave request
//  s_we_o       out  S_NUM      write enable
//  s_addr_bo    out  S_NUM*32   address (full 32 bits passed through)
//  s_be_o       out  S_NUM*4    byte enables
//  s_wdata_bo   out  S_NUM*32   write data
//  s_ack_i      in   S_NUM      slave accepted request
//  s_resp_i     in   S_NUM      slave read data valid (in order per slave)
//  s_rdata_bi   in   S_NUM*32   slave read data
// BEHAVIOUR
//  - Handshake: a transfer occurs on the cycle where req&&ack. Masters hold req and fields stable until ack.
//    Writes get no resp. Each read gets exactly one resp, >=1 cycle after its ack.
//  - Decode: tgt = addr[31:28]. tgt>=S_NUM selects the error slave (index S_NUM).
//  - Eligibility of master k: cnt[k]==0, or (cur[k]==tgt and cnt[k]<MAX_OUTST); applies to reads and writes.
//    A read to slave j is additionally blocked while FIFO j is full (push-with-pop same cycle counts as not full).
//  - Arbitration, per slave: round-robin among eligible requesters, search starting at ptr[j].
//    When s_req_o[j]=1 and s_ack_i[j]=0, the grant is locked and remains locked until ack.
//    On ack: ptr[j] <= grant+1 (mod M_NUM), lock cleared.
//  - Forwarding: s_req_o and fields are combinationally muxed from the granted master.
//    m_ack_o[k] = s_ack_i[grant] & granted; ack is combinational.
//  - Read accept at slave j: push master ID into FIFO j; cnt[k]++, cur[k]<=j.
//    On s_resp_i[j] with FIFO j non-empty: pop ID i; m_resp_o[i]=1 and m_rdata_bo[i]=s_rdata_bi[j], combinational.
//    On that same resp, cnt[i]--. Simultaneous accept and resp on one master: cnt unchanged.
//  - s_resp_i[j] with FIFO j empty: dropped silently; no counter underflow.
//  - Error slave: acks any granted request in the same cycle.
//    For a read, it drives resp with ERR_RDATA exactly 1 cycle later, via its own FIFO (depth RD_DEPTH).
//  - Reset values: all outputs 0; ptr=0; locks clear; FIFOs empty; cnt=0; cur=0.
//    Reset mid-transfer discards all outstanding IDs; later slave resps are dropped.
//  - FIFO pointers: log2(RD_DEPTH)+1 bits, wrap naturally. cnt width: clog2(MAX_OUTST+1).
//  - Unselected m_rdata_bo lanes = 0. Idle slave fields = 0.
// STRUCTURE
//  - magma_xbar_defs.vh: BUS_AW=32, BUS_DW=32, BUS_BEW=4, SEL_MSB=31, SEL_LSB=28, clog2 function.
//  - Sub-module magma_xbar_idfifo (synchronous FIFO of master IDs, push/pop/full/empty).
//    Instantiated S_NUM+1 times via generate; arbiters and counters stay inline in generate loops.
// TESTING
//  1. M0 writes 0x1000_0010 (slave 1), ack at cycle 0 -> s_req_o[1]=1 with same addr/be/wdata; m_resp_o stays 0.
//  2. M0..M3 all read slave 0 continuously, slave always acks -> grants strictly rotate 0,1,2,3,0.
//     Each m_resp_o[k] returns that slave's data in issue order.
//  3. Slave 2 delays ack 5 cycles while M1 (higher RR priority) starts requesting -> grant stays on M3 until ack.
//  4. M0 issues 4 reads to slave 0, slave withholds resp -> 5th read not acked (cnt=MAX_OUTST).
//     M0 write to slave 1 also blocked until all 4 resps return.
//  5. M2 reads 0xF000_0000 -> ack same cycle; m_resp_o[2]=1 next cycle with rdata 32'hDEADBEEF.
//  6. Assert rst_i with 3 reads outstanding on slave 0, then slave pulses resp -> no m_resp_o; cnt=0.
//     Next read completes normally.

Source files
------------

// File: rtl/magma_xbar_pkg.sv
// magma_xbar_pkg
//   Shared bus geometry for the magma crossbar slice: address/data/byte-enable
//   widths, the slave-select field position inside the address, and a
//   constant-evaluable ceil(log2) helper used to size indices and pointers.
package magma_xbar_pkg;

  localparam int BUS_AW  = 32;
  localparam int BUS_DW  = 32;
  localparam int BUS_BEW = 4;
  localparam int SEL_MSB = 31;
  localparam int SEL_LSB = 28;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/magma_xbar_idfifo.sv
// magma_xbar_idfifo
//   Synchronous FIFO of master IDs, one per slave, remembering which master
//   owns each outstanding read so responses can be steered back in order.
// Ports
//   clk_i, rst_i  clock, synchronous active-high reset (pointers only)
//   push_i/id_i   enqueue a master ID
//   pop_i         dequeue the head entry
//   full_o        DEPTH entries held
//   empty_o       no entries held
//   head_o        ID at the head (valid while !empty_o)
module magma_xbar_idfifo
  import magma_xbar_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDW   = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push_i,
  input  logic [IDW-1:0] id_i,
  input  logic           pop_i,
  output logic           full_o,
  output logic           empty_o,
  output logic [IDW-1:0] head_o
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]    r_wp;
  logic [AW:0]    r_rp;
  logic [IDW-1:0] r_mem [DEPTH];
  logic           w_do_push;
  logic           w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty_o   = (r_wp == r_rp);
  assign full_o    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);
  assign head_o    = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_do_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wp[AW-1:0]] <= id_i;
  end

endmodule

// File: rtl/magma_xbar.sv
// magma_xbar
//   M_NUM x S_NUM interconnect for the magma req/ack/resp bus. Slave index is
//   addr[31:28]; indices >= S_NUM go to an internal error slave (index S_NUM)
//   that acks immediately and answers reads with ERR_RDATA one cycle later.
//   Per-target round-robin arbitration with grant lock while the slave stalls,
//   per-target read-ID FIFOs for response steering, and per-master
//   outstanding-read limits that also pin a master to one target at a time.
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   m_req_i/m_we_i/m_addr_bi/m_be_i/m_wdata_bi   master request side
//   m_ack_o, m_resp_o, m_rdata_bo     master accept / read response
//   s_req_o/s_we_o/s_addr_bo/s_be_o/s_wdata_bo   slave request side
//   s_ack_i, s_resp_i, s_rdata_bi     slave accept / read response
module magma_xbar
  import magma_xbar_pkg::*;
#(
  parameter int               M_NUM     = 5,
  parameter int               S_NUM     = 5,
  parameter int               RD_DEPTH  = 4,
  parameter int               MAX_OUTST = 4,
  parameter logic [BUS_DW-1:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [M_NUM-1:0]          m_req_i,
  input  logic [M_NUM-1:0]          m_we_i,
  input  logic [M_NUM*BUS_AW-1:0]   m_addr_bi,
  input  logic [M_NUM*BUS_BEW-1:0]  m_be_i,
  input  logic [M_NUM*BUS_DW-1:0]   m_wdata_bi,
  output logic [M_NUM-1:0]          m_ack_o,
  output logic [M_NUM-1:0]          m_resp_o,
  output logic [M_NUM*BUS_DW-1:0]   m_rdata_bo,
  output logic [S_NUM-1:0]          s_req_o,
  output logic [S_NUM-1:0]          s_we_o,
  output logic [S_NUM*BUS_AW-1:0]   s_addr_bo,
  output logic [S_NUM*BUS_BEW-1:0]  s_be_o,
  output logic [S_NUM*BUS_DW-1:0]   s_wdata_bo,
  input  logic [S_NUM-1:0]          s_ack_i,
  input  logic [S_NUM-1:0]          s_resp_i,
  input  logic [S_NUM*BUS_DW-1:0]   s_rdata_bi
);

  localparam int NT  = S_NUM + 1;
  localparam int MIW = (M_NUM > 1) ? clog2(M_NUM) : 1;
  localparam int CW  = clog2(MAX_OUTST + 1);
  localparam int TW  = SEL_MSB - SEL_LSB + 1;

  logic [TW-1:0]        w_tgt  [M_NUM];
  logic [M_NUM-1:0]     w_elig;
  logic [M_NUM-1:0]     w_inc;
  logic [M_NUM-1:0]     w_cand [NT];
  logic [MIW-1:0]       w_gnt  [NT];
  logic [MIW-1:0]       w_head [NT];
  logic [NT-1:0]        w_gvld;
  logic [NT-1:0]        w_sack;
  logic [NT-1:0]        w_sresp;
  logic [NT-1:0]        w_full;
  logic [NT-1:0]        w_empty;
  logic [NT-1:0]        w_pop;
  logic [NT-1:0]        w_push;
  logic [NT-1:0]        w_rfull;
  logic [NT*BUS_DW-1:0] w_srdata;
  logic [MIW:0]         w_sum;
  logic [MIW-1:0]       w_idx;

  logic [MIW-1:0]       r_ptr  [NT];
  logic [MIW-1:0]       r_lgnt [NT];
  logic [NT-1:0]        r_lock;
  logic [CW-1:0]        r_cnt  [M_NUM];
  logic [TW-1:0]        r_cur  [M_NUM];
  logic                 r_err_resp_p1;

  // The error slave sits at the top index: always acks, answers from its own
  // delayed response pulse and returns the fixed error word.
  assign w_sack   = {1'b1, s_ack_i};
  assign w_sresp  = {r_err_resp_p1, s_resp_i};
  assign w_srdata = {ERR_RDATA, s_rdata_bi};
  assign w_pop    = w_sresp & ~w_empty;
  // A FIFO popping this cycle can take a push, so it is not treated as full.
  assign w_rfull  = w_full & ~w_pop;

  always_comb begin
    for (int k = 0; k < M_NUM; k++) begin
      w_tgt[k] = m_addr_bi[BUS_AW*k+SEL_LSB +: TW];
      if (w_tgt[k] >= TW'(S_NUM)) w_tgt[k] = TW'(S_NUM);
      w_elig[k] = (r_cnt[k] == '0) ||
                  ((r_cur[k] == w_tgt[k]) && (r_cnt[k] < CW'(MAX_OUTST)));
      for (int j = 0; j < NT; j++) begin
        if (!m_we_i[k] && w_rfull[j] && (w_tgt[k] == TW'(j))) w_elig[k] = 1'b0;
      end
    end
    for (int j = 0; j < NT; j++) begin
      w_cand[j] = '0;
      for (int k = 0; k < M_NUM; k++) begin
        w_cand[j][k] = m_req_i[k] && w_elig[k] && (w_tgt[k] == TW'(j));
      end
    end
  end

  // Round-robin search from ptr; a stalled grant stays locked until acked.
  always_comb begin
    w_sum = '0;
    w_idx = '0;
    for (int j = 0; j < NT; j++) begin
      w_gvld[j] = 1'b0;
      w_gnt[j]  = '0;
      if (r_lock[j]) begin
        w_gvld[j] = m_req_i[r_lgnt[j]];
        w_gnt[j]  = r_lgnt[j];
      end else begin
        for (int i = 0; i < M_NUM; i++) begin
          w_sum = {1'b0, r_ptr[j]} + (MIW+1)'(i);
          if (w_sum >= (MIW+1)'(M_NUM)) w_sum = w_sum - (MIW+1)'(M_NUM);
          w_idx = w_sum[MIW-1:0];
          if (!w_gvld[j] && w_cand[j][w_idx]) begin
            w_gvld[j] = 1'b1;
            w_gnt[j]  = w_idx;
          end
        end
      end
    end
  end

  always_comb begin
    s_req_o    = '0;
    s_we_o     = '0;
    s_addr_bo  = '0;
    s_be_o     = '0;
    s_wdata_bo = '0;
    for (int j = 0; j < S_NUM; j++) begin
      if (w_gvld[j]) begin
        s_req_o[j] = 1'b1;
        s_we_o[j]  = m_we_i[w_gnt[j]];
        s_addr_bo[BUS_AW*j +: BUS_AW]   = m_addr_bi[BUS_AW*w_gnt[j] +: BUS_AW];
        s_be_o[BUS_BEW*j +: BUS_BEW]    = m_be_i[BUS_BEW*w_gnt[j] +: BUS_BEW];
        s_wdata_bo[BUS_DW*j +: BUS_DW]  = m_wdata_bi[BUS_DW*w_gnt[j] +: BUS_DW];
      end
    end
  end

  always_comb begin
    m_ack_o    = '0;
    m_resp_o   = '0;
    m_rdata_bo = '0;
    w_inc      = '0;
    w_push     = '0;
    for (int j = 0; j < NT; j++) begin
      if (w_gvld[j] && w_sack[j]) begin
        m_ack_o[w_gnt[j]] = 1'b1;
        if (!m_we_i[w_gnt[j]]) begin
          w_inc[w_gnt[j]] = 1'b1;
          w_push[j]       = 1'b1;
        end
      end
      if (w_pop[j]) begin
        m_resp_o[w_head[j]] = 1'b1;
        m_rdata_bo[BUS_DW*w_head[j] +: BUS_DW] = w_srdata[BUS_DW*j +: BUS_DW];
      end
    end
  end

  // Stage p1: error-slave response one cycle after its read is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_resp_p1 <= 1'b0;
      r_lock        <= '0;
      for (int j = 0; j < NT; j++) begin
        r_ptr[j]  <= '0;
        r_lgnt[j] <= '0;
      end
      for (int k = 0; k < M_NUM; k++) begin
        r_cnt[k] <= '0;
        r_cur[k] <= '0;
      end
    end else begin
      r_err_resp_p1 <= w_push[S_NUM];
      for (int j = 0; j < NT; j++) begin
        if (w_gvld[j] && w_sack[j]) begin
          r_lock[j] <= 1'b0;
          r_ptr[j]  <= (w_gnt[j] == MIW'(M_NUM-1)) ? '0 : w_gnt[j] + 1'b1;
        end else if (w_gvld[j]) begin
          r_lock[j] <= 1'b1;
          r_lgnt[j] <= w_gnt[j];
        end
      end
      for (int k = 0; k < M_NUM; k++) begin
        if (w_inc[k] && !m_resp_o[k])      r_cnt[k] <= r_cnt[k] + 1'b1;
        else if (!w_inc[k] && m_resp_o[k]) r_cnt[k] <= r_cnt[k] - 1'b1;
        if (w_inc[k]) r_cur[k] <= w_tgt[k];
      end
    end
  end

  for (genvar j = 0; j < NT; j++) begin : g_fifo
    magma_xbar_idfifo #(
      .DEPTH (RD_DEPTH),
      .IDW   (MIW)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_push[j]),
      .id_i    (w_gnt[j]),
      .pop_i   (w_pop[j]),
      .full_o  (w_full[j]),
      .empty_o (w_empty[j]),
      .head_o  (w_head[j])
    );
  end

endmodule

// File: tb/tb_magma_xbar.sv
// tb_magma_xbar
//   Directed cycle-by-cycle stimulus for magma_xbar (5 masters, 5 slaves)
//   with hand-computed expected values on grants, forwarded fields and
//   steered read responses.
module tb_magma_xbar;

  localparam int M = 5;
  localparam int S = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [M-1:0]   m_req, m_we, m_ack, m_resp;
  logic [M*32-1:0] m_addr, m_wdata, m_rdata;
  logic [M*4-1:0] m_be;
  logic [S-1:0]   s_req, s_we, s_ack, s_resp;
  logic [S*32-1:0] s_addr, s_wdata, s_rdata;
  logic [S*4-1:0] s_be;

  int n_chk  = 0;
  int n_fail = 0;
  int ord [5] = '{0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  magma_xbar #(
    .M_NUM(M), .S_NUM(S), .RD_DEPTH(4), .MAX_OUTST(4), .ERR_RDATA(32'hDEADBEEF)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_we_i(m_we), .m_addr_bi(m_addr), .m_be_i(m_be),
    .m_wdata_bi(m_wdata), .m_ack_o(m_ack), .m_resp_o(m_resp), .m_rdata_bo(m_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_bo(s_addr), .s_be_o(s_be),
    .s_wdata_bo(s_wdata), .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane(input logic [159:0] v, input int k);
    return v[32*k +: 32];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_req = '0; m_we = '0; m_addr = '0; m_be = '0; m_wdata = '0;
    s_ack = '0; s_resp = '0; s_rdata = '0;
  endtask

  task automatic mset(input int k, input logic req, input logic we,
                      input logic [31:0] a, input logic [31:0] d);
    m_req[k] = req;
    m_we[k]  = we;
    m_addr[32*k +: 32] = a;
    m_be[4*k +: 4]     = 4'hF;
    m_wdata[32*k +: 32] = d;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #4;
    chk("rst_sreq", 32'(s_req), 32'h0);
    chk("rst_mack", 32'(m_ack), 32'h0);
    chk("rst_mresp", 32'(m_resp), 32'h0);
    chk("rst_rdata0", lane(m_rdata, 0), 32'h0);
    step();
    rst = 1'b0;

    // Write forwarded to slave 1, acked the same cycle, never a response.
    mset(0, 1'b1, 1'b1, 32'h1000_0010, 32'hA5A5_0001);
    s_ack[1] = 1'b1;
    #3;
    chk("t1_sreq", 32'(s_req), 32'h2);
    chk("t1_swe", 32'(s_we), 32'h2);
    chk("t1_addr", lane(s_addr, 1), 32'h1000_0010);
    chk("t1_be", 32'(s_be[7:4]), 32'hF);
    chk("t1_wdata", lane(s_wdata, 1), 32'hA5A5_0001);
    chk("t1_idle_addr0", lane(s_addr, 0), 32'h0);
    chk("t1_ack", 32'(m_ack), 32'h1);
    chk("t1_resp", 32'(m_resp), 32'h0);
    step();
    idle();
    #3;
    chk("t1_noresp", 32'(m_resp), 32'h0);
    chk("t1_sreq_idle", 32'(s_req), 32'h0);

    // Four masters hammer slave 0; grants rotate, responses follow issue order.
    step();
    for (int k = 0; k < 4; k++) mset(k, 1'b1, 1'b0, 32'(k * 4), 32'h0);
    s_ack[0] = 1'b1;
    #3;
    chk("t2_ack0", 32'(m_ack), 32'h1);
    chk("t2_resp0", 32'(m_resp), 32'h0);
    for (int c = 1; c < 5; c++) begin
      step();
      s_resp[0] = 1'b1;
      s_rdata[31:0] = 32'hD000_0000 + 32'(c - 1);
      #3;
      chk("t2_ack", 32'(m_ack), 32'(1) << ord[c]);
      chk("t2_resp", 32'(m_resp), 32'(1) << ord[c-1]);
      chk("t2_rdata", lane(m_rdata, ord[c-1]), 32'hD000_0000 + 32'(c - 1));
    end
    step();
    m_req = '0;
    s_ack = '0;
    s_resp[0] = 1'b1;
    s_rdata[31:0] = 32'hD000_0004;
    #3;
    chk("t2_ack_last", 32'(m_ack), 32'h0);
    chk("t2_resp_last", 32'(m_resp), 32'h1);
    chk("t2_rdata_last", lane(m_rdata, 0), 32'hD000_0004);
    step();
    idle();
    #3;
    chk("t2_quiet", 32'(m_resp), 32'h0);

    // Slave 2 stalls M3; M1 arriving later must not steal the locked grant.
    step();
    mset(3, 1'b1, 1'b1, 32'h2000_0030, 32'h0000_3333);
    #3;
    chk("t3_sreq", 32'(s_req), 32'h4);
    chk("t3_addr_m3", lane(s_addr, 2), 32'h2000_0030);
    chk("t3_noack", 32'(m_ack), 32'h0);
    for (int c = 1; c < 5; c++) begin
      step();
      mset(1, 1'b1, 1'b1, 32'h2000_0010, 32'h0000_1111);
      #3;
      chk("t3_locked_addr", lane(s_addr, 2), 32'h2000_0030);
      chk("t3_locked_noack", 32'(m_ack), 32'h0);
    end
    step();
    s_ack[2] = 1'b1;
    #3;
    chk("t3_ack_m3", 32'(m_ack), 32'h8);
    chk("t3_wdata_m3", lane(s_wdata, 2), 32'h0000_3333);
    step();
    mset(3, 1'b0, 1'b0, 32'h0, 32'h0);
    #3;
    chk("t3_ack_m1", 32'(m_ack), 32'h2);
    chk("t3_addr_m1", lane(s_addr, 2), 32'h2000_0010);

    // Outstanding limit: 5th read stalls, write elsewhere waits for all resps.
    step();
    idle();
    mset(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    s_ack[0] = 1'b1;
    #3;
    chk("t4_rd_ack", 32'(m_ack), 32'h1);
    for (int c = 0; c < 3; c++) begin
      step();
      #3;
      chk("t4_rd_ack", 32'(m_ack), 32'h1);
    end
    step();
    #3;
    chk("t4_5th_noack", 32'(m_ack), 32'h0);
    chk("t4_5th_nosreq", 32'(s_req), 32'h0);
    step();
    mset(0, 1'b1, 1'b1, 32'h1000_0040, 32'h0000_4444);
    s_ack[1] = 1'b1;
    #3;
    chk("t4_wr_blocked", 32'(m_ack), 32'h0);
    chk("t4_wr_nosreq", 32'(s_req), 32'h0);
    for (int r = 0; r < 4; r++) begin
      step();
      s_resp[0] = 1'b1;
      s_rdata[31:0] = 32'hC000_0000 + 32'(r);
      #3;
      chk("t4_resp", 32'(m_resp), 32'h1);
      chk("t4_rdata", lane(m_rdata, 0), 32'hC000_0000 + 32'(r));
      chk("t4_wr_wait", 32'(m_ack), 32'h0);
    end
    step();
    s_resp = '0;
    #3;
    chk("t4_wr_ack", 32'(m_ack), 32'h1);
    chk("t4_wr_sreq", 32'(s_req), 32'h2);

    // Unmapped addresses go to the error slave (0xF and the first index past S).
    step();
    idle();
    mset(2, 1'b1, 1'b0, 32'hF000_0000, 32'h0);
    #3;
    chk("t5_ack", 32'(m_ack), 32'h4);
    chk("t5_nosreq", 32'(s_req), 32'h0);
    step();
    idle();
    #3;
    chk("t5_resp", 32'(m_resp), 32'h4);
    chk("t5_rdata", lane(m_rdata, 2), 32'hDEADBEEF);
    chk("t5_lane0_zero", lane(m_rdata, 0), 32'h0);
    step();
    mset(4, 1'b1, 1'b0, 32'h5000_0004, 32'h0);
    #3;
    chk("t5b_ack", 32'(m_ack), 32'h10);
    chk("t5b_noresp", 32'(m_resp), 32'h0);
    step();
    idle();
    #3;
    chk("t5b_resp", 32'(m_resp), 32'h10);
    chk("t5b_rdata", lane(m_rdata, 4), 32'hDEADBEEF);

    // Reset with three reads in flight: later resps vanish, counters cleared.
    step();
    mset(1, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
    s_ack[0] = 1'b1;
    #3;
    chk("t6_rd_ack", 32'(m_ack), 32'h2);
    for (int c = 0; c < 2; c++) begin
      step();
      #3;
      chk("t6_rd_ack", 32'(m_ack), 32'h2);
    end
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int r = 0; r < 3; r++) begin
      s_resp[0] = 1'b1;
      s_rdata[31:0] = 32'hBAD0_0000 + 32'(r);
      #3;
      chk("t6_dropped", 32'(m_resp), 32'h0);
      step();
    end
    idle();
    mset(1, 1'b1, 1'b1, 32'h1000_0050, 32'h0000_5555);
    s_ack[1] = 1'b1;
    #3;
    chk("t6_cnt_clear", 32'(m_ack), 32'h2);
    step();
    idle();
    mset(1, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
    s_ack[0] = 1'b1;
    #3;
    chk("t6_new_rd_ack", 32'(m_ack), 32'h2);
    step();
    idle();
    s_resp[0] = 1'b1;
    s_rdata[31:0] = 32'h600D_0001;
    #3;
    chk("t6_new_resp", 32'(m_resp), 32'h2);
    chk("t6_new_rdata", lane(m_rdata, 1), 32'h600D_0001);
    step();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
